hilo_ctrl: RTL



---
 rtl/hilo_ctrl_if.sv | 20 ++
 rtl/hilo_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl_if.sv
// Controller-to-divider bus: registered operands and start pulse out, results and status back.
interface hilo_ctrl_if;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_init;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_end;
    logic        div_exc;

    modport master (
        output dividend, divisor, div_init,
        input  div_hi, div_lo, div_end, div_exc
    );

    modport slave (
        input  dividend, divisor, div_init,
        output div_hi, div_lo, div_end, div_exc
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register file and divide sequencer (IDLE -> ISSUE -> WAIT) in front of a multi-cycle divider.
// Optional WAIT abort counter is built when HILO_TIMEOUT_EN is defined.
module hilo_ctrl #(
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       hi,
    output logic [31:0]       lo,
    output logic              busy,
    output logic              div_zero,
    output logic              timeout,
    hilo_ctrl_if.master       div
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t      state_reg, state_next;
    logic        div_end_d_reg;
    logic [31:0] hi_reg, lo_reg;
    logic [31:0] dividend_reg, divisor_reg;
    logic        div_zero_reg, div_zero_next;
    logic        load_ops, load_result, write_hi, write_lo;
    logic        busy_c, div_init_c;
    logic        end_rise;
    logic        tmo_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Only a fresh edge counts; a done level left over from the previous op is ignored.
    assign end_rise = div.div_end & ~div_end_d_reg;

`ifdef HILO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             timeout_reg;

    assign tmo_hit = (state_reg == S_WAIT) && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_reg <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && state_next == S_ISSUE)
                tmo_cnt_reg <= '0;
            else if (state_reg == S_WAIT)
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            timeout_reg <= tmo_hit && !end_rise && !div.div_exc;
        end
    end

    assign timeout = timeout_reg;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (op_start && (op_b != 32'd0)) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (end_rise || div.div_exc || tmo_hit) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c        = (state_reg != S_IDLE);
        div_init_c    = (state_reg == S_ISSUE);
        load_ops      = 1'b0;
        load_result   = 1'b0;
        write_hi      = 1'b0;
        write_lo      = 1'b0;
        div_zero_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                load_ops      = op_start && (op_b != 32'd0);
                div_zero_next = op_start && (op_b == 32'd0);
                write_hi      = mthi_we;
                write_lo      = mtlo_we;
            end
            S_WAIT: begin
                // Completion takes priority over a simultaneous exception.
                load_result   = end_rise;
                div_zero_next = div.div_exc && !end_rise;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_end_d_reg <= 1'b0;
            div_zero_reg  <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
        end else begin
            div_end_d_reg <= div.div_end;
            div_zero_reg  <= div_zero_next;
            if (load_ops) begin
                dividend_reg <= op_a;
                divisor_reg  <= op_b;
            end
            if (load_result) begin
                hi_reg <= div.div_hi;
                lo_reg <= div.div_lo;
            end else begin
                if (write_hi) hi_reg <= wdata;
                if (write_lo) lo_reg <= wdata;
            end
        end
    end

    assign hi           = hi_reg;
    assign lo           = lo_reg;
    assign busy         = busy_c;
    assign div_zero     = div_zero_reg;
    assign div.div_init = div_init_c;
    assign div.dividend = dividend_reg;
    assign div.divisor  = divisor_reg;

endmodule
